// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl
//   Bouncing-light controller for an LED bank. A single lit LED sweeps from
//   MSB to LSB and back. Each step is taken on a prescaler tick whose period
//   is DIV_BASE >> speed clocks, with a minimum of 1. A run starts on 'start',
//   aborts on 'stop', and ends on its own after a latched number of direction
//   reversals. A bounce_limit of 0 means the run never ends by itself.
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high, dominates all inputs
//   start        one-cycle command, begins a run from IDLE only
//   stop         one-cycle command, aborts a run; wins over start and tick
//   speed[1:0]   live rate select, tick period = DIV_BASE >> speed (min 1)
//   bounce_limit reversals per run, latched at start; 0 = unlimited
//   leds         one-hot pattern while running, zero otherwise
//   dir          0 = moving toward LSB, 1 = moving toward MSB
//   busy         high while sweeping (RIGHT/LEFT)
//   bounces      reversals in the current/last run, saturating at 255
//   done         one-cycle pulse when a run ends by reaching the limit
module led_sweep_ctrl #(
  parameter int WIDTH    = 18,
  parameter int DIV_BASE = 12_500_000,
  parameter int DIV_W    = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       speed,
  input  logic [7:0]       bounce_limit,
  output logic [WIDTH-1:0] leds,
  output logic             dir,
  output logic             busy,
  output logic [7:0]       bounces,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RIGHT  = 2'd1,
    LEFT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] BASE    = DIV_W'(DIV_BASE);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] period;
  logic [7:0]       limit;
  logic             tick;
  logic [7:0]       bounces_nx;
  logic             hit_limit;

  // Reversal counter saturates rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Tick uses >= so a live speed increase never lets cnt run past the
  // new, shorter period.
  always_comb begin
    shifted    = BASE >> speed;
    period     = (shifted == '0) ? ONE : shifted;
    tick       = (cnt >= (period - ONE));
    bounces_nx = sat_inc8(bounces);
    hit_limit  = (limit != 8'd0) && (bounces_nx >= limit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      leds    <= '0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      bounces <= 8'd0;
      done    <= 1'b0;
      cnt     <= '0;
      limit   <= 8'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          leds <= '0;
          dir  <= 1'b0;
          busy <= 1'b0;
          if (start && !stop) begin
            state   <= RIGHT;
            leds    <= MSB_ONE;
            busy    <= 1'b1;
            bounces <= 8'd0;
            limit   <= bounce_limit;
          end
        end

        RIGHT, LEFT: begin
          if (stop) begin
            state <= IDLE;
            leds  <= '0;
            dir   <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (tick) begin
            cnt <= '0;
            if ((state == RIGHT) ? !leds[0] : !leds[WIDTH-1]) begin
              leds <= (state == RIGHT) ? (leds >> 1) : (leds << 1);
            end else begin
              // At an end: hold the LED for one tick of dwell and reverse.
              bounces <= bounces_nx;
              dir     <= (state == RIGHT);
              if (hit_limit) begin
                state <= FINISH;
                done  <= 1'b1;
                leds  <= '0;
                busy  <= 1'b0;
              end else begin
                state <= (state == RIGHT) ? LEFT : RIGHT;
              end
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end

        FINISH: begin
          state <= IDLE;
          dir   <= 1'b0;
          leds  <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_sweep_ctrl.md
# led_sweep_ctrl

Controller for the 18-LED bouncing-light display. It sequences a one-hot LED pattern that sweeps from MSB to LSB and back, at a rate set by a programmable tick prescaler. It accepts start and stop commands and counts direction reversals. It ends a run automatically after a latched number of reversals. It sits between the board buttons/switches and the LED bank, and replaces the free-running, clock-per-step shifter.

## Interface
Parameters:
- WIDTH, 18, number of LEDs (≥2).
- DIV_BASE, 12_500_000, tick period in clocks at speed=0 (4 Hz at 50 MHz).
- DIV_W, 24, prescaler counter width; must hold DIV_BASE-1.

Ports:
- clock  in  1  sole clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- start  in  1  one-cycle command; begins a run from IDLE, ignored otherwise.
- stop  in  1  one-cycle command; aborts a run; priority over start and tick.
- speed  in  2  live rate select; tick period P = DIV_BASE >> speed (min 1).
- bounce_limit  in  8  reversals per run, latched at start; 0 = run forever.
- leds  out  WIDTH  one-hot LED pattern; all zero when not running.
- dir  out  1  0 = moving toward LSB, 1 = moving toward MSB.
- busy  out  1  high in RIGHT/LEFT states.
- bounces  out  8  reversals in current/last run, saturates at 255.
- done  out  1  one-cycle pulse when a run completes by limit.

## Operation
- States: IDLE, RIGHT, LEFT, FINISH. Reset value: IDLE, leds=0, dir=0, busy=0, bounces=0, done=0, prescaler=0, latched limit=0.
- Prescaler: runs only in RIGHT/LEFT. It is cleared in IDLE and FINISH and on start. tick=1 on a cycle where cnt ≥ P-1, and cnt then returns to 0. Otherwise cnt increments. The ≥ compare makes a speed change take effect without overrun.
- IDLE: on start, go to RIGHT and load leds = 1<<(WIDTH-1). Set dir=0, bounces=0, and latch bounce_limit.
- RIGHT, on tick:
  - If leds[0]=0, shift leds right by 1.
  - If leds[0]=1, reverse. leds are unchanged for a one-tick dwell, dir=1, bounces+1, and the state goes to LEFT.
- LEFT, on tick:
  - If leds[WIDTH-1]=0, shift leds left by 1.
  - Otherwise reverse. leds are unchanged, dir=0, bounces+1, and the state goes to RIGHT.
- Limit: on a reversal tick where the latched limit ≠0 and the new bounces ≥ limit, go to FINISH instead of the opposite direction. bounces takes its new value.
- FINISH: lasts one cycle with done=1, leds=0, busy=0. Then IDLE, with dir=0.
- stop in RIGHT/LEFT: next state IDLE, leds=0, dir=0, no done pulse, bounces holds.
- stop in IDLE/FINISH: no effect.
- start in RIGHT/LEFT/FINISH: ignored.
- start and stop asserted together: stop wins; from IDLE nothing happens.
- bounces saturates at 255. With limit=0 the sweep continues indefinitely.
- Exactly one leds bit is set in RIGHT/LEFT at all times. leds never shift past either end.

## Timing
- Registered outputs, updated on the edge that changes state; no combinational input→output paths.
- start sampled at edge k: leds=MSB, busy=1 after edge k.
- First shift occurs P clocks after edge k.
- Full sweep cycle: (WIDTH-1) shift ticks + 1 dwell tick per direction, i.e. 2·WIDTH ticks per round trip.
- stop/reset: outputs cleared after the same edge that samples them (1-cycle latency).
- done is high for exactly the one cycle after the limiting reversal tick edge.

## Test plan
- Reset with start held high → leds=0, busy=0, dir=0, bounces=0, done=0 for every cycle reset is high.
- DIV_BASE=8, speed=0, start → leds=0x20000. leds=0x10000 exactly 8 clocks later. leds=0x00001 after tick 17. Tick 18 keeps 0x00001 with dir=1, bounces=1. Tick 19 gives 0x00002.
- bounce_limit=2, speed=3 (P=1) → reversal at LSB (bounces=1), then at MSB the state goes to FINISH. done is pulsed for one cycle with leds=0, busy=0, bounces=2. Then IDLE.
- Mid-sweep stop with start also asserted → next cycle leds=0, busy=0, no done. A later start restarts from 0x20000 with bounces=0.
- speed changed 0→3 while prescaler count=5 (DIV_BASE=8) → tick on the next cycle, then every cycle.
- start pulse while busy → no change to leds/bounces. Reset asserted mid-run → all outputs 0 after that edge.
